// File: rtl/scc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scc_mem_pkg
//  Description : Shared types and constants for the scc memory responders.
//  Revision    : 1.0  initial release
// ============================================================================
package scc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0]  ERR_NONE         = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN     = 2'b01;
    localparam logic [1:0]  ERR_RANGE        = 2'b10;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Misalignment outranks range: a misaligned PC is reported as such
    // even when it also lies beyond the array.
    function automatic logic [1:0] fetch_err(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] w_word_addr;
        w_word_addr = {2'b00, addr[31:2]};
        if (addr[1:0] != 2'b00) begin
            return ERR_MISALIGN;
        end
        if ((w_word_addr >> aw) != 32'd0) begin
            return ERR_RANGE;
        end
        return ERR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_array
//  Description : 2**ADDR_W x 32 storage, synchronous write, asynchronous read.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    // Contents are deliberately not reset so a preloaded program survives rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Fetch-side instruction memory with fixed response latency.
//  Revision    : 1.0  initial release
// ============================================================================
import scc_mem_pkg::*;

module imem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_instruction,
    output logic [31:0]       rsp_addr,
    output logic [1:0]        err_bits,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              busy
);

    localparam logic [2:0] C_CNT_INIT = 3'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pend_word_q, pend_word_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [1:0]  pend_err_q, pend_err_d;
    logic [31:0] out_word_q, out_word_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [1:0]  out_err_q, out_err_d;

    logic        w_accept;
    logic [31:0] w_rdata;
    logic [1:0]  w_err;
    logic [31:0] w_word;

    imem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (load_en & clk_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (req_addr[ADDR_W+1:2]),
        .rdata_o (w_rdata)
    );

    assign req_ready = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && !load_en;
    assign w_accept  = req_valid && req_ready && clk_en;
    assign w_err     = fetch_err(req_addr, ADDR_W);
    assign w_word    = (w_err == ERR_NONE) ? w_rdata : NOP_WORD;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_word_d = pend_word_q;
        pend_addr_d = pend_addr_q;
        pend_err_d  = pend_err_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        if (clk_en) begin
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        pend_word_d = w_word;
                        pend_addr_d = req_addr;
                        pend_err_d  = w_err;
                        cnt_d       = C_CNT_INIT;
                        if (LATENCY == 1) begin
                            state_d    = ST_RESP;
                            out_word_d = w_word;
                            out_addr_d = req_addr;
                            out_err_d  = w_err;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end
                end
                ST_WAIT: begin
                    // The counter hits zero on the same edge that enters RESP.
                    if (cnt_q <= 3'd1) begin
                        state_d    = ST_RESP;
                        cnt_d      = 3'd0;
                        out_word_d = pend_word_q;
                        out_addr_d = pend_addr_q;
                        out_err_d  = pend_err_q;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            pend_word_q <= 32'd0;
            pend_addr_q <= 32'd0;
            pend_err_q  <= ERR_NONE;
            out_word_q  <= 32'd0;
            out_addr_q  <= 32'd0;
            out_err_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_word_q <= pend_word_d;
            pend_addr_q <= pend_addr_d;
            pend_err_q  <= pend_err_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
        end
    end

    assign rsp_valid       = (state_q == ST_RESP);
    assign busy            = (state_q != ST_IDLE);
    assign rsp_instruction = out_word_q;
    assign rsp_addr        = out_addr_q;
    assign err_bits        = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_responder
//  Description : Directed bench for imem_responder at LATENCY 2 and 1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_responder;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready, rsp_valid, busy;
    logic [31:0] rsp_instruction, rsp_addr;
    logic [1:0]  err_bits;

    logic        req_valid1 = 1'b0;
    logic [31:0] req_addr1 = '0;
    logic        req_ready1, rsp_valid1, busy1;
    logic [31:0] rsp_instruction1, rsp_addr1;
    logic [1:0]  err_bits1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_W(AW), .LATENCY(2), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_instruction(rsp_instruction), .rsp_addr(rsp_addr),
        .err_bits(err_bits), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .busy(busy)
    );

    imem_responder #(.ADDR_W(AW), .LATENCY(1), .NOP_WORD(32'h0000_0000)) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
        .rsp_valid(rsp_valid1), .rsp_instruction(rsp_instruction1), .rsp_addr(rsp_addr1),
        .err_bits(err_bits1), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .busy(busy1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Present one request to the LATENCY=2 instance and wait for its pulse;
    // cyc counts negedges from the accept edge, -1 on timeout.
    task automatic do_req(input logic [31:0] a, output int cyc);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int t;
        int idx;
        int pulse_t [3];
        logic [31:0] pulse_w [3];
        logic [31:0] b2b_addr [3];

        vecs[0] = '{32'h0000_000C, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h0000_0000, 32'h1000_0000, 2'b00};
        vecs[2] = '{32'h0000_0004, 32'h1000_0111, 2'b00};
        vecs[3] = '{32'h0000_0006, 32'h0000_0000, 2'b01};
        vecs[4] = '{32'h0000_1000, 32'h0000_0000, 2'b10};
        vecs[5] = '{32'h0000_1002, 32'h0000_0000, 2'b01};
        vecs[6] = '{32'h0000_0FFC, 32'hCAFE_F00D, 2'b00};
        vecs[7] = '{32'hFFFF_FFF0, 32'h0000_0000, 2'b10};

        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_instr", rsp_instruction, 32'd0);
        chk("rst_addr", rsp_addr, 32'd0);
        chk("rst_err", 32'(err_bits), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        load_word(10'd0, 32'h1000_0000);
        load_word(10'd1, 32'h1000_0111);
        load_word(10'd2, 32'h1000_0222);
        load_word(10'd3, 32'hDEAD_BEEF);
        load_word(10'd1023, 32'hCAFE_F00D);

        for (int v = 0; v < 8; v++) begin
            do_req(vecs[v].addr, cyc);
            chk($sformatf("vec%0d_latency", v), 32'(cyc), 32'd2);
            chk($sformatf("vec%0d_instr", v), rsp_instruction, vecs[v].word);
            chk($sformatf("vec%0d_addr", v), rsp_addr, vecs[v].addr);
            chk($sformatf("vec%0d_err", v), 32'(err_bits), 32'(vecs[v].err));
        end

        // Back-to-back: next address presented during each RESP cycle.
        b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
        @(negedge clk);
        idx = 0; t = 0;
        req_valid = 1'b1; req_addr = b2b_addr[0];
        for (int i = 0; i < 20 && idx < 3; i++) begin
            @(negedge clk);
            t++;
            if (rsp_valid) begin
                pulse_t[idx] = t;
                pulse_w[idx] = rsp_instruction;
                idx++;
                if (idx < 3) req_addr = b2b_addr[idx];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(idx), 32'd3);
        if (idx == 3) begin
            chk("b2b_first", 32'(pulse_t[0]), 32'd2);
            chk("b2b_gap1", 32'(pulse_t[1] - pulse_t[0]), 32'd2);
            chk("b2b_gap2", 32'(pulse_t[2] - pulse_t[1]), 32'd2);
            chk("b2b_w0", pulse_w[0], 32'h1000_0000);
            chk("b2b_w1", pulse_w[1], 32'h1000_0111);
            chk("b2b_w2", pulse_w[2], 32'h1000_0222);
        end

        // Load with a request pending on the port blocks acceptance.
        @(negedge clk);
        @(negedge clk);
        load_en = 1'b1; load_addr = 10'd0; load_data = 32'h1000_0000;
        req_valid = 1'b1; req_addr = 32'h0;
        #1 chk("load_blocks_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        load_en = 1'b0; req_valid = 1'b0;
        chk("load_no_accept", 32'(busy), 32'd0);

        // Overwriting a pending request's word during WAIT keeps the old data.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        load_en = 1'b1; load_addr = 10'd2; load_data = 32'h5555_5555;
        @(negedge clk);
        load_en = 1'b0;
        chk("wait_load_valid", 32'(rsp_valid), 32'd1);
        chk("wait_load_old", rsp_instruction, 32'h1000_0222);
        do_req(32'h8, cyc);
        chk("wait_load_new", rsp_instruction, 32'h5555_5555);

        // clk_en low for three cycles while waiting.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'hC;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            clk_en = !(i >= 1 && i <= 3);
            if (rsp_valid && i > 1) begin
                cyc = i;
                break;
            end
        end
        clk_en = 1'b1;
        chk("clken_latency", 32'(cyc), 32'd5);
        chk("clken_instr", rsp_instruction, 32'hDEAD_BEEF);

        // Reset during WAIT drops the response; array survives reset.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_ready", 32'(req_ready), 32'd1);
        chk("rst_wait_instr", rsp_instruction, 32'd0);
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) idx++;
        end
        chk("rst_wait_no_rsp", 32'(idx), 32'd0);
        do_req(32'hC, cyc);
        chk("array_kept", rsp_instruction, 32'hDEAD_BEEF);

        // LATENCY=1 instance: single then continuous requests.
        @(negedge clk);
        req_valid1 = 1'b1; req_addr1 = 32'h0;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        chk("lat1_valid", 32'(rsp_valid1), 32'd1);
        chk("lat1_instr", rsp_instruction1, 32'h1000_0000);
        @(negedge clk);
        chk("lat1_idle", 32'(rsp_valid1), 32'd0);
        req_valid1 = 1'b1; req_addr1 = 32'h4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("lat1_stream%0d", i), 32'(rsp_valid1), 32'd1);
            chk($sformatf("lat1_stream_w%0d", i), rsp_instruction1, 32'h1000_0111);
        end
        req_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat1_done", 32'(busy1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory side of the fetch interface in `scc`. It accepts the fetch stage's byte program counter and returns the addressed 32-bit instruction word after a fixed, parameterised latency, flagging misaligned and out-of-range fetches on `err_bits`. It also provides a preload write port so a bench or boot loader can fill program memory before and during execution.

## Interface
- `ADDR_W`, 10: word-address width; the array holds 2**ADDR_W 32-bit words.
- `LATENCY`, 2: cycles from request accept to `rsp_valid`; legal range 1..7.
- `NOP_WORD`, 32'h0000_0000: word returned on any errored fetch.

- `clk`  in  1  core clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `clk_en`  in  1  clock enable. When low, all state, counter, outputs and array are frozen.
- `req_valid`  in  1  fetch request present.
- `req_addr`  in  32  byte address, i.e. the program counter.
- `req_ready`  out  1  responder can accept this cycle (combinational).
- `rsp_valid`  out  1  one-cycle pulse; response fields valid.
- `rsp_instruction`  out  32  fetched word, or `NOP_WORD` on error.
- `rsp_addr`  out  32  `req_addr` of the request being answered.
- `err_bits`  out  2  2'b00 ok, 2'b01 misaligned, 2'b10 out of range.
- `load_en`  in  1  preload write strobe.
- `load_addr`  in  ADDR_W  preload word address.
- `load_data`  in  32  preload word.
- `busy`  out  1  a request is outstanding (state != IDLE).

## Operation
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: latency counter running.
  - RESP: `rsp_valid` = 1 for this cycle.
- `req_ready` = (state is IDLE or RESP) && !load_en.
- Accept occurs when `req_valid && req_ready && clk_en`. On accept:
  - Latch `req_addr`.
  - Read the array combinationally at `req_addr[ADDR_W+1:2]` and latch the word.
  - Compute the error code.
  - Load the counter with LATENCY-1.
- Transitions after an accept:
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT, decrement the counter each enabled cycle, and enter RESP when the counter reaches 0.
- In RESP:
  - A new accept goes to WAIT or RESP by the same rules, so back-to-back requests are supported.
  - With no accept, return to IDLE.
- Error code, with misaligned taking priority:
  - 2'b01 if `req_addr[1:0] != 0`.
  - Else 2'b10 if `req_addr[31:2] >= 2**ADDR_W`.
  - Any errored response returns `NOP_WORD`.
- Preload:
  - `load_en` writes `load_data` into `array[load_addr]` on the clock edge, in any state.
  - A load never collides with an accept, because `req_ready` is low whenever `load_en` is high.
  - A load to the address of an already-accepted request does not change that request's response: data was sampled at accept.
- `rsp_instruction`, `rsp_addr` and `err_bits` are registered. They update only on entry to RESP and hold until the next response.
- Array contents are not affected by reset.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `rsp_valid`, `busy` = 0.
  - `rsp_instruction`, `rsp_addr` = 0; `err_bits` = 2'b00.
  - `req_ready` = 1 while `load_en` = 0.
- Reset asserted mid-request drops the pending response; no `rsp_valid` follows it.
- Latency: accept at edge N, then `rsp_valid` is high during the cycle after edge N+LATENCY-1. With `clk_en` held high, that is LATENCY cycles after the accept cycle.
- Throughput: one response per LATENCY cycles.
- `clk_en` low during WAIT stretches the latency by exactly the number of disabled cycles.
- `clk_en` low during RESP holds `rsp_valid` high until the next enabled edge; consumers qualify `rsp_valid` with `clk_en`.
- `req_valid` may drop without penalty. A request not accepted leaves no state behind.

## Structure
- Shared package `scc_mem_pkg`:
  - State enum (IDLE/WAIT/RESP).
  - Error-code constants ERR_NONE, ERR_MISALIGN, ERR_RANGE.
  - Default `NOP_WORD`.
- Sub-module `imem_array`: 2**ADDR_W × 32 storage, with a synchronous write port and an asynchronous read port.
- The FSM, counter and response registers live in `imem_responder`.

## Test plan
- Latency and data: preload word 3 = 32'hDEAD_BEEF; LATENCY=2; request 32'h0000_000C → `rsp_valid` 2 cycles after accept, `rsp_instruction` = 32'hDEAD_BEEF, `rsp_addr` = 32'h0000_000C, `err_bits` = 00.
- Back-to-back: requests 0x0, 0x4 and 0x8 accepted in consecutive RESP cycles → three `rsp_valid` pulses spaced by LATENCY, returning words 0, 1 and 2 in order.
- Errors:
  - 32'h0000_0006 → `err_bits` 01, `NOP_WORD`.
  - 32'h0000_1000 (ADDR_W=10) → `err_bits` 10.
  - 32'h0000_1002 → `err_bits` 01 (priority).
- Load interaction:
  - `load_en` high with `req_valid` high → `req_ready` = 0, no accept.
  - Load to a pending request's address during WAIT → the response still returns the old word.
- Enable and reset:
  - `clk_en` low for 3 cycles during WAIT → response delayed by exactly 3 cycles.
  - `rst` pulsed during WAIT → no `rsp_valid`, `busy` = 0, `req_ready` = 1 next cycle.
- LATENCY=1: request 0x0 → `rsp_valid` the cycle after accept; continuous requests → `rsp_valid` high every cycle.
